shift_exec_stage: RTL and testbench
===================================

SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 SHALL have parameter BITS, default 32, giving the datapath width.
REQ-002 SHALL have parameter DEPTH, default 2, giving the output-buffer entry count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream operation present.
REQ-006 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-007 SHALL have port funct3, input, 3, RV32I funct3 field.
REQ-008 SHALL have port funct7_5, input, 1, instruction bit 30, selecting arithmetic right shift.
REQ-009 SHALL have port rs1, input, BITS, the value to shift.
REQ-010 SHALL have port rs2, input, BITS, register or immediate operand; only bits [4:0] are used as the shift amount.
REQ-011 SHALL have port rd, input, 5, destination register index.
REQ-012 SHALL have port out_valid, output, 1, buffered result present.
REQ-013 SHALL have port out_ready, input, 1, downstream consumes this cycle.
REQ-014 SHALL have ports out_result (BITS), out_rd (5) and out_illegal (1), all outputs, all taken from the head buffer entry.
REQ-015 SHALL have port op_count, output, 16, count of accepted operations; saturates at 0xFFFF.

Function
REQ-016 SHALL accept an operation on any edge where in_valid and in_ready are both high ("push").
REQ-017 SHALL pop the head entry on any edge where out_valid and out_ready are both high.
REQ-018 SHALL decode alufn as follows: funct3=001 gives 00 (SHL); funct3=101 with funct7_5=0 gives 01 (SHR logical); funct3=101 with funct7_5=1 gives 11 (SRA).
REQ-019 SHALL set out_illegal=1 and out_result=0 for any other funct3; the entry is still buffered and counted.
REQ-020 SHALL compute the result combinationally from rs1, rs2[4:0] and alufn at push, and write it into the buffer on the same edge; out_valid rises one cycle after push.
REQ-021 SHALL force the stored result to 0 when rd=0; out_illegal keeps its decoded value in that case.
REQ-022 SHALL drive in_ready = (count < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-023 SHALL drive out_valid = (count != 0).
REQ-024 SHALL, on simultaneous push and pop, leave count unchanged and keep entry order FIFO.
REQ-025 SHALL ignore in_valid while count=DEPTH, even if out_ready is high in the same cycle.
REQ-026 SHALL wrap the read and write pointers modulo DEPTH.
REQ-027 SHALL sustain 1 operation/cycle throughput while out_ready is held high.
REQ-028 SHALL increment op_count by 1 per push, saturating at 0xFFFF.
REQ-029 SHALL keep outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-030 SHALL, on rst high, immediately clear count, both pointers and op_count, and drive out_valid=0, out_result=0, out_rd=0 and out_illegal=0.
REQ-031 SHALL drive in_ready=1 from the first edge after rst deasserts.
REQ-032 SHALL discard all buffered entries when rst asserts mid-operation; no partial result is emitted afterwards.

Structure
REQ-033 SHALL take the ALUFN_SHL=00, ALUFN_SHR=01, ALUFN_SRA=11 constants and the FUNCT3_SLL and FUNCT3_SRL constants from the shared CPU constants package.
REQ-034 SHALL instantiate the existing combinational shifter block (parameters: BITS; ports: alufn, a, b, out) as its only sub-module.
REQ-035 SHALL implement the buffer inline as register arrays.

Verification
REQ-036 Scenario SLL: rs1=0x1AFFFFFF, rs2=3, funct3=001, rd=5 -> one cycle later out_result=0xD7FFFFF8, out_rd=5, out_illegal=0.
REQ-037 Scenario SRL/SRA: rs1=0x80000000, rs2=4, funct3=101; with funct7_5=0 -> out_result=0x08000000; with funct7_5=1 -> out_result=0xF8000000.
REQ-038 Scenario backpressure: out_ready=0 and 3 pushes attempted -> in_ready=0 after 2 accepted; raise out_ready -> results emerge in order and the 3rd operation is accepted.
REQ-039 Scenario illegal and x0: funct3=000 -> out_illegal=1, out_result=0; rd=0 with a legal shift -> out_result=0.
REQ-040 Scenario streaming: 10 back-to-back pushes with out_ready=1 -> 10 results on consecutive cycles and op_count=10.
REQ-041 Scenario reset: assert rst with 2 entries buffered -> out_valid=0 and op_count=0 immediately; no stale output appears after release.

Source files
------------

// File: rtl/shift_exec_stage_pkg.sv
// shift_exec_stage_pkg: shared CPU constants (ALU shift function codes, RV32I shift funct3 values)
package shift_exec_stage_pkg;
  localparam logic [1:0] ALUFN_SHL = 2'b00;
  localparam logic [1:0] ALUFN_SHR = 2'b01;
  localparam logic [1:0] ALUFN_SRA = 2'b11;
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRL = 3'b101;
endpackage

// File: rtl/shift_exec_stage_shifter.sv
// shift_exec_stage_shifter: combinational shifter; alufn selects SHL/SHR/SRA of a by b, result on out
module shift_exec_stage_shifter
  import shift_exec_stage_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [1:0]      alufn,
  input  logic [BITS-1:0] a,
  input  logic [4:0]      b,
  output logic [BITS-1:0] out
);
  logic signed [BITS-1:0] sra;
  assign sra = $signed(a) >>> b;
  assign out = alufn == ALUFN_SHL ? a << b : alufn == ALUFN_SRA ? sra : a >> b;
endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: RV32I shift execute stage with DEPTH-entry output FIFO; in_valid/in_ready in, out_valid/out_ready + out_result/out_rd/out_illegal out, op_count of accepted ops
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [BITS-1:0] rs1,
  input  logic [BITS-1:0] rs2,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic [15:0]     op_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0]   count;
  logic [PW-1:0]   rp, wp;
  logic [BITS-1:0] res_q [DEPTH];
  logic [4:0]      rd_q [DEPTH];
  logic            ill_q [DEPTH];
  logic [1:0]      alufn;
  logic            illegal, push, pop;
  logic [BITS-1:0] sh_out, result;
  logic            unused_rs2;
  assign unused_rs2 = ^rs2[BITS-1:5];
  shift_exec_stage_shifter #(.BITS(BITS)) u_shifter (
    .alufn (alufn),
    .a     (rs1),
    .b     (rs2[4:0]),
    .out   (sh_out)
  );
  always_comb begin
    illegal     = funct3 != FUNCT3_SLL && funct3 != FUNCT3_SRL;
    alufn       = funct3 == FUNCT3_SLL ? ALUFN_SHL : funct7_5 ? ALUFN_SRA : ALUFN_SHR;
    result      = illegal || rd == 5'd0 ? '0 : sh_out;
    in_ready    = count < CW'(DEPTH);
    out_valid   = count != '0;
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    out_result  = out_valid ? res_q[rp] : '0;
    out_rd      = out_valid ? rd_q[rp] : '0;
    out_illegal = out_valid && ill_q[rp];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count    <= '0;
      rp       <= '0;
      wp       <= '0;
      op_count <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (push && op_count != 16'hFFFF) op_count <= op_count + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      res_q[wp] <= result;
      rd_q[wp]  <= rd;
      ill_q[wp] <= illegal;
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: table vectors, backpressure/streaming/reset sequences and a random run against a queue model
module tb_shift_exec_stage;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, funct7_5 = 0, out_valid, out_ready = 0, out_illegal;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0, out_result;
  logic [4:0]  rd = 0, out_rd;
  logic [15:0] op_count;
  int checks = 0, errors = 0;

  shift_exec_stage #(.BITS(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .funct7_5(funct7_5), .rs1(rs1), .rs2(rs2), .rd(rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_illegal(out_illegal), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] res;
  } entry_t;

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  function automatic entry_t ref_op(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b, logic [4:0] r);
    int unsigned sh;
    logic [63:0] w;
    entry_t e;
    sh = b % 32;
    e.rd = r;
    e.ill = 0;
    if (f3 == 3'b001) begin
      w = {32'b0, a} << sh;
      e.res = w[31:0];
    end else if (f3 == 3'b101) begin
      w = f7 ? {{32{a[31]}}, a} : {32'b0, a};
      w = w >> sh;
      e.res = w[31:0];
    end else begin
      e.ill = 1;
      e.res = 0;
    end
    if (r == 0) e.res = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    in_valid = 1; funct3 = f3; funct7_5 = f7; rs1 = a; rs2 = b; rd = r;
  endtask

  task automatic chk_head(input string nm, input entry_t e);
    chk({nm, " valid"}, 64'(out_valid), 64'(1));
    chk({nm, " head"}, 64'({out_illegal, out_rd, out_result}), 64'(e));
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    #3;
    rst = 0;
    step();
  endtask

  vec_t vecs[11];
  entry_t q[$];
  entry_t e1, e2, e3;
  int model_cnt;

  initial begin
    vecs[0]  = '{3'b001, 0, 32'h1AFFFFFF, 32'd3,        5'd5,  32'hD7FFFFF8, 0};
    vecs[1]  = '{3'b101, 0, 32'h80000000, 32'd4,        5'd7,  32'h08000000, 0};
    vecs[2]  = '{3'b101, 1, 32'h80000000, 32'd4,        5'd7,  32'hF8000000, 0};
    vecs[3]  = '{3'b000, 0, 32'h12345678, 32'd1,        5'd3,  32'h00000000, 1};
    vecs[4]  = '{3'b001, 0, 32'h0000000F, 32'd2,        5'd0,  32'h00000000, 0};
    vecs[5]  = '{3'b011, 1, 32'hFFFFFFFF, 32'd1,        5'd0,  32'h00000000, 1};
    vecs[6]  = '{3'b101, 1, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF, 0};
    vecs[7]  = '{3'b101, 0, 32'h80000000, 32'h0000003F, 5'd9,  32'h00000001, 0};
    vecs[8]  = '{3'b001, 1, 32'h00000001, 32'h00000020, 5'd31, 32'h00000001, 0};
    vecs[9]  = '{3'b111, 0, 32'h00000005, 32'd1,        5'd4,  32'h00000000, 1};
    vecs[10] = '{3'b101, 1, 32'h7FFFFFF0, 32'd4,        5'd1,  32'h07FFFFFF, 0};

    #2;
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset outputs", 64'({out_result, out_rd, out_illegal}), 0);
    chk("reset op_count", 64'(op_count), 0);
    rst = 0;
    step();
    chk("in_ready after reset", 64'(in_ready), 1);

    out_ready = 1;
    foreach (vecs[i]) begin
      drive(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].rd);
      step();
      in_valid = 0;
      chk_head($sformatf("vec%0d", i), '{vecs[i].exp_ill, vecs[i].rd, vecs[i].exp_res});
      step();
      chk($sformatf("vec%0d drained", i), 64'(out_valid), 0);
    end
    chk("op_count after vectors", 64'(op_count), 11);

    do_reset();
    e1 = ref_op(3'b001, 0, 32'h11, 32'd1, 5'd1);
    e2 = ref_op(3'b101, 1, 32'h80000000, 32'd8, 5'd2);
    e3 = ref_op(3'b101, 0, 32'hF0, 32'd4, 5'd3);
    drive(3'b001, 0, 32'h11, 32'd1, 5'd1);
    step();
    drive(3'b101, 1, 32'h80000000, 32'd8, 5'd2);
    step();
    chk("bp full in_ready", 64'(in_ready), 0);
    drive(3'b101, 0, 32'hF0, 32'd4, 5'd3);
    step();
    chk("bp held in_ready", 64'(in_ready), 0);
    chk_head("bp stable first", e1);
    chk("bp op_count held", 64'(op_count), 2);
    out_ready = 1;
    step();
    chk_head("bp second", e2);
    chk("bp full push ignored", 64'(op_count), 2);
    chk("bp in_ready reopened", 64'(in_ready), 1);
    step();
    in_valid = 0;
    chk_head("bp third", e3);
    step();
    chk("bp drained", 64'(out_valid), 0);
    chk("bp op_count", 64'(op_count), 3);

    do_reset();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(3'b001, 0, 32'(i + 1), 32'(i), 5'(i + 1));
      step();
      chk_head($sformatf("stream%0d", i), ref_op(3'b001, 0, 32'(i + 1), 32'(i), 5'(i + 1)));
    end
    in_valid = 0;
    step();
    chk("stream drained", 64'(out_valid), 0);
    chk("stream op_count", 64'(op_count), 10);

    do_reset();
    drive(3'b001, 0, 32'h1, 32'd4, 5'd6);
    step();
    step();
    in_valid = 0;
    chk("pre-reset full", 64'(in_ready), 0);
    #2 rst = 1;
    #1;
    chk("async reset out_valid", 64'(out_valid), 0);
    chk("async reset op_count", 64'(op_count), 0);
    chk("async reset outputs", 64'({out_result, out_rd, out_illegal}), 0);
    out_ready = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-reset quiet%0d", i), 64'({out_valid, out_result}), 0);
    end
    chk("post-reset in_ready", 64'(in_ready), 1);

    do_reset();
    q.delete();
    model_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      logic push, pop;
      logic [2:0] f3s[4];
      entry_t e;
      f3s = '{3'b001, 3'b101, 3'b101, 3'($urandom)};
      in_valid = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 6;
      funct3 = f3s[$urandom % 4];
      funct7_5 = 1'($urandom);
      rs1 = $urandom;
      rs2 = $urandom;
      rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      push = in_valid && q.size() < 2;
      pop = out_ready && q.size() > 0;
      e = ref_op(funct3, funct7_5, rs1, rs2, rd);
      step();
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        model_cnt++;
      end
      chk($sformatf("rand%0d flags", c), 64'({out_valid, in_ready}), 64'({q.size() != 0, q.size() < 2}));
      if (q.size() != 0)
        chk($sformatf("rand%0d head", c), 64'({out_illegal, out_rd, out_result}), 64'(q[0]));
      chk($sformatf("rand%0d op_count", c), 64'(op_count), 64'(model_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
